// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle datapath: sequences fetch/decode/execute/mem/writeback
// and drives datapath enables, memory strobes and the ALUop/FuncCode pair.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Opcode,
  input  logic [3:0] InstrFunc,
  input  logic       MemReady,
  output logic [3:0] ALUop,
  output logic [3:0] FuncCode,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       RegWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       IllegalOp,
  output logic       Halted
);

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LOAD  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_BEQ   = 4'b0011;
  localparam logic [3:0] OP_JUMP  = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b1111;
  localparam logic [3:0] SUB_CODE = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  state_t state, state_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    ALUop       = ALU_ADD;
    FuncCode    = 4'b0000;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSrc       = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    RegWrite    = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    IllegalOp   = 1'b0;
    Halted      = 1'b0;

    case (state)
      IDLE: state_next = FETCH;

      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (MemReady) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = DECODE;
        end
      end

      // ALU precomputes the branch target while the opcode is decoded
      DECODE: begin
        ALUSrcB = 2'b10;
        case (Opcode)
          OP_JUMP: begin
            PCWrite    = 1'b1;
            PCSrc      = 2'b10;
            state_next = FETCH;
          end
          OP_HALT:                             state_next = HALT;
          OP_RTYPE, OP_LOAD, OP_STORE, OP_BEQ: state_next = EXEC;
          default: begin
            IllegalOp  = 1'b1;
            state_next = FETCH;
          end
        endcase
      end

      EXEC: begin
        ALUSrcA    = 1'b1;
        state_next = FETCH;
        case (Opcode)
          OP_RTYPE: begin
            ALUop      = ALU_PASS;
            FuncCode   = InstrFunc;
            state_next = WB;
          end
          OP_LOAD, OP_STORE: begin
            ALUSrcB    = 2'b10;
            state_next = MEM;
          end
          OP_BEQ: begin
            ALUop       = ALU_PASS;
            FuncCode    = SUB_CODE;
            PCWriteCond = 1'b1;
            PCSrc       = 2'b01;
          end
          default: ALUSrcA = 1'b0;
        endcase
      end

      MEM: begin
        IorD     = 1'b1;
        MemRead  = (Opcode == OP_LOAD);
        MemWrite = (Opcode == OP_STORE);
        if (MemReady || !(MemRead || MemWrite))
          state_next = (Opcode == OP_LOAD) ? WB : FETCH;
      end

      WB: begin
        RegWrite   = 1'b1;
        RegDst     = (Opcode == OP_RTYPE);
        MemToReg   = (Opcode == OP_LOAD);
        state_next = FETCH;
      end

      HALT: Halted = 1'b1;

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: each instruction is expanded into its expected per-cycle output trace
// and compared cycle by cycle against the control FSM.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] Opcode = 4'b0000;
  logic [3:0] InstrFunc = 4'b0000;
  logic       MemReady = 1'b0;
  logic [3:0] ALUop, FuncCode;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond;
  logic       RegWrite, MemToReg, RegDst, IllegalOp, Halted;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .InstrFunc(InstrFunc), .MemReady(MemReady),
    .ALUop(ALUop), .FuncCode(FuncCode), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .RegWrite(RegWrite), .MemToReg(MemToReg), .RegDst(RegDst),
    .IllegalOp(IllegalOp), .Halted(Halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] aluop;
    logic [3:0] func;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       iord, mr, mw, irw, pcw, pcwc, rw, m2r, rdst, ill, halted;
  } outs_t;

  typedef struct {
    outs_t e;
    logic  rdy;
    logic  junk_op;
  } step_t;

  function automatic outs_t get_act();
    outs_t a;
    a.aluop = ALUop;     a.func = FuncCode;  a.srca = ALUSrcA;   a.srcb = ALUSrcB;
    a.pcsrc = PCSrc;     a.iord = IorD;      a.mr = MemRead;     a.mw = MemWrite;
    a.irw = IRWrite;     a.pcw = PCWrite;    a.pcwc = PCWriteCond; a.rw = RegWrite;
    a.m2r = MemToReg;    a.rdst = RegDst;    a.ill = IllegalOp;  a.halted = Halted;
    return a;
  endfunction

  // Expected trace of one instruction, derived from the instruction-level rules.
  task automatic run_instr(input string name, input logic [3:0] op, input logic [3:0] func,
                           input int fs, input int ms);
    step_t q[$];
    step_t s;
    outs_t e;
    outs_t act;
    bit known = op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hF};
    for (int i = 0; i <= fs; i++) begin
      e = '0; e.mr = 1'b1; e.srcb = 2'b01;
      if (i == fs) begin e.irw = 1'b1; e.pcw = 1'b1; end
      s.e = e; s.rdy = (i == fs); s.junk_op = 1'b1; q.push_back(s);
    end
    e = '0; e.srcb = 2'b10;
    if (op == 4'h4) begin e.pcw = 1'b1; e.pcsrc = 2'b10; end
    if (!known) e.ill = 1'b1;
    s.e = e; s.rdy = 1'($urandom); s.junk_op = 1'b0; q.push_back(s);
    if (op inside {4'h0, 4'h1, 4'h2, 4'h3}) begin
      e = '0; e.srca = 1'b1;
      case (op)
        4'h0: begin e.aluop = 4'hF; e.func = func; end
        4'h3: begin e.aluop = 4'hF; e.func = 4'h1; e.pcwc = 1'b1; e.pcsrc = 2'b01; end
        default: e.srcb = 2'b10;
      endcase
      s.e = e; s.rdy = 1'($urandom); q.push_back(s);
    end
    if (op inside {4'h1, 4'h2}) begin
      for (int i = 0; i <= ms; i++) begin
        e = '0; e.iord = 1'b1; e.mr = (op == 4'h1); e.mw = (op == 4'h2);
        s.e = e; s.rdy = (i == ms); q.push_back(s);
      end
    end
    if (op inside {4'h0, 4'h1}) begin
      e = '0; e.rw = 1'b1; e.rdst = (op == 4'h0); e.m2r = (op == 4'h1);
      s.e = e; s.rdy = 1'($urandom); q.push_back(s);
    end
    if (op == 4'hF) begin
      e = '0; e.halted = 1'b1;
      for (int i = 0; i < 20; i++) begin
        s.e = e; s.rdy = 1'($urandom); s.junk_op = 1'b1; q.push_back(s);
      end
    end
    foreach (q[k]) begin
      @(negedge clk);
      Opcode    = q[k].junk_op ? 4'($urandom) : op;
      InstrFunc = q[k].junk_op ? 4'($urandom) : func;
      MemReady  = q[k].rdy;
      #1;
      act = get_act();
      n_checks++;
      if (act !== q[k].e) begin
        n_fail++;
        $display("FAIL %s op=%h cycle %0d: got %h expected %h", name, op, k, act, q[k].e);
      end
    end
  endtask

  task automatic check_zero(input string name);
    outs_t act = get_act();
    n_checks++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs %h expected all zero", name, act);
    end
  endtask

  // Leaves the FSM in IDLE just past a falling edge; the next cycle is FETCH.
  task automatic apply_reset(input string name);
    @(negedge clk);
    reset = 1'b1;
    MemReady = 1'($urandom);
    #1 check_zero({name, "_asserted"});
    @(negedge clk);
    reset = 1'b0;
    #1 check_zero({name, "_idle"});
  endtask

  task automatic test_reset();
    #1 check_zero("reset_initial");
    @(negedge clk);
    reset = 1'b0;
    #1 check_zero("idle_after_reset");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      MemReady = 1'b0;
      #1;
      n_checks++;
      if (MemRead !== 1'b1 || IRWrite !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_stall: MemRead=%b IRWrite=%b expected 1 0", MemRead, IRWrite);
      end
    end
    #2 reset = 1'b1;
    #1 check_zero("reset_mid_fetch");
    @(negedge clk);
    reset = 1'b0;
    #1 check_zero("idle_after_mid_fetch_reset");
    run_instr("fetch_after_reset", 4'h4, 4'h0, 0, 0);
  endtask

  task automatic test_rtype();
    run_instr("rtype", 4'h0, 4'b0110, 0, 0);
    run_instr("rtype_stall", 4'h0, 4'b1010, 2, 0);
  endtask

  task automatic test_load_store();
    run_instr("load_stall", 4'h1, 4'h0, 0, 3);
    run_instr("load", 4'h1, 4'h5, 0, 0);
    run_instr("store", 4'h2, 4'h0, 0, 0);
    run_instr("store_stall", 4'h2, 4'h3, 1, 2);
  endtask

  task automatic test_branch_jump();
    run_instr("beq", 4'h3, 4'h9, 0, 0);
    run_instr("jump", 4'h4, 4'h0, 0, 0);
    run_instr("beq_after_jump", 4'h3, 4'h2, 0, 0);
  endtask

  task automatic test_illegal();
    run_instr("illegal_7", 4'h7, 4'h0, 0, 0);
    run_instr("illegal_e", 4'hE, 4'h4, 1, 0);
    run_instr("after_illegal", 4'h0, 4'h3, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 14)) : 4'($urandom_range(0, 4));
      run_instr("random", op, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  task automatic test_halt();
    run_instr("halt", 4'hF, 4'h0, 0, 0);
    apply_reset("halt_reset");
    run_instr("after_halt", 4'h1, 4'h0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_store();
    test_branch_jump();
    test_illegal();
    test_back_to_back();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
